// File: rtl/cva6_pma_region_lookup.sv
// PMA region lookup: classifies an address against the execute, cached and
// non-idempotent rule tables, scanning one rule index per cycle.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_valid_i/req_ready_o    request handshake (ready only while idle)
//   req_addr_i                 address, captured at the request handshake
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_exec_o/rsp_cached_o/rsp_nonidem_o  attribute bits, zero unless rsp_valid_o
//   busy_o                     lookup in progress (scanning or holding a response)
module cva6_pma_region_lookup #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned NrExecRules    = 3,
  parameter logic [16*AddrWidth-1:0] ExecBase =
    {{(13*AddrWidth){1'b0}}, 64'h8000_0000, 64'h1_0000, 64'h0},
  parameter logic [16*AddrWidth-1:0] ExecLen =
    {{(13*AddrWidth){1'b0}}, 64'h4000_0000, 64'h1_0000, 64'h1000},
  parameter int unsigned NrCachedRules  = 1,
  parameter logic [16*AddrWidth-1:0] CachedBase = {{(15*AddrWidth){1'b0}}, 64'h8000_0000},
  parameter logic [16*AddrWidth-1:0] CachedLen  = {{(15*AddrWidth){1'b0}}, 64'h4000_0000},
  parameter int unsigned NrNonIdemRules = 2,
  parameter logic [16*AddrWidth-1:0] NonIdemBase = {{(14*AddrWidth){1'b0}}, 64'h0, 64'h0},
  parameter logic [16*AddrWidth-1:0] NonIdemLen  = {{(14*AddrWidth){1'b0}}, 64'h0, 64'h0}
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_exec_o,
  output logic                 rsp_cached_o,
  output logic                 rsp_nonidem_o,
  output logic                 busy_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam int unsigned MaxEc  = (NrExecRules > NrCachedRules) ? NrExecRules : NrCachedRules;
  localparam int unsigned NrScan = (MaxEc > NrNonIdemRules) ? MaxEc : NrNonIdemRules;
  localparam logic [3:0]  LastIdx = (NrScan > 0) ? 4'(NrScan - 1) : 4'd0;

  logic [1:0]           state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 exec_q, exec_d;
  logic                 cached_q, cached_d;
  logic                 nonidem_q, nonidem_d;

  logic [15:0] exec_hit, cached_hit, nonidem_hit;

  // Limit is formed one bit wider so a region ending at the top of the
  // address space does not wrap to zero.
  function automatic logic rule_hit(input logic [AddrWidth-1:0] addr,
                                    input logic [AddrWidth-1:0] base,
                                    input logic [AddrWidth-1:0] len);
    logic [AddrWidth:0] limit;
    limit = {1'b0, base} + {1'b0, len};
    return (len != '0) && (base <= addr) && ({1'b0, addr} < limit);
  endfunction

  // Rules beyond a table's count are tied off, so the scan can index all
  // three tables with the same idx.
  for (genvar i = 0; i < 16; i++) begin : g_rule
    assign exec_hit[i]    = (i < NrExecRules) &&
        rule_hit(addr_q, ExecBase[i*AddrWidth +: AddrWidth], ExecLen[i*AddrWidth +: AddrWidth]);
    assign cached_hit[i]  = (i < NrCachedRules) &&
        rule_hit(addr_q, CachedBase[i*AddrWidth +: AddrWidth],
                 CachedLen[i*AddrWidth +: AddrWidth]);
    assign nonidem_hit[i] = (i < NrNonIdemRules) &&
        rule_hit(addr_q, NonIdemBase[i*AddrWidth +: AddrWidth],
                 NonIdemLen[i*AddrWidth +: AddrWidth]);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    exec_d    = exec_q;
    cached_d  = cached_q;
    nonidem_d = nonidem_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          idx_d     = 4'd0;
          exec_d    = 1'b0;
          cached_d  = 1'b0;
          nonidem_d = 1'b0;
          state_d   = (NrScan > 0) ? StScan : StResp;
        end
      end
      StScan: begin
        exec_d    = exec_q    | exec_hit[idx_q];
        cached_d  = cached_q  | cached_hit[idx_q];
        nonidem_d = nonidem_q | nonidem_hit[idx_q];
        idx_d     = idx_q + 4'd1;
        if (idx_q == LastIdx) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      addr_q    <= '0;
      exec_q    <= 1'b0;
      cached_q  <= 1'b0;
      nonidem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      exec_q    <= exec_d;
      cached_q  <= cached_d;
      nonidem_q <= nonidem_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign rsp_valid_o   = (state_q == StResp);
  assign rsp_exec_o    = rsp_valid_o & exec_q;
  assign rsp_cached_o  = rsp_valid_o & cached_q;
  assign rsp_nonidem_o = rsp_valid_o & nonidem_q;
  assign busy_o        = (state_q == StScan) || (state_q == StResp);

endmodule

// File: tb/tb_cva6_pma_region_lookup.sv
// Directed bench for cva6_pma_region_lookup: default tables plus two
// overridden instances (single top-of-memory exec rule, and no rules at all).
module tb_cva6_pma_region_lookup;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_addr;
  logic        rsp_exec, rsp_cached, rsp_nonidem, busy;

  // Shared stimulus for the two overridden instances
  logic        a_valid, a_ready_rsp;
  logic [63:0] a_addr;
  logic        w_req_ready, w_rsp_valid, w_exec, w_cached, w_nonidem, w_busy;
  logic        z_req_ready, z_rsp_valid, z_exec, z_cached, z_nonidem, z_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cva6_pma_region_lookup u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_exec_o    (rsp_exec),
    .rsp_cached_o  (rsp_cached),
    .rsp_nonidem_o (rsp_nonidem),
    .busy_o        (busy)
  );

  cva6_pma_region_lookup #(
    .NrExecRules    (1),
    .ExecBase       ({{(15*64){1'b0}}, 64'hFFFF_FFFF_FFFF_F000}),
    .ExecLen        ({{(15*64){1'b0}}, 64'h1000}),
    .NrCachedRules  (0),
    .NrNonIdemRules (0)
  ) u_wrap (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (a_valid),
    .req_ready_o   (w_req_ready),
    .req_addr_i    (a_addr),
    .rsp_valid_o   (w_rsp_valid),
    .rsp_ready_i   (a_ready_rsp),
    .rsp_exec_o    (w_exec),
    .rsp_cached_o  (w_cached),
    .rsp_nonidem_o (w_nonidem),
    .busy_o        (w_busy)
  );

  cva6_pma_region_lookup #(
    .NrExecRules    (0),
    .NrCachedRules  (0),
    .NrNonIdemRules (0)
  ) u_zero (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (a_valid),
    .req_ready_o   (z_req_ready),
    .req_addr_i    (a_addr),
    .rsp_valid_o   (z_rsp_valid),
    .rsp_ready_i   (a_ready_rsp),
    .rsp_exec_o    (z_exec),
    .rsp_cached_o  (z_cached),
    .rsp_nonidem_o (z_nonidem),
    .busy_o        (z_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request to u_dut from IDLE; returns the cycle (handshake = 0)
  // in which rsp_valid was first seen, and the flags {exec,cached,nonidem}.
  task automatic lookup(input logic [63:0] addr, output int lat, output logic [2:0] fl);
    tick();
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    fl = {rsp_exec, rsp_cached, rsp_nonidem};
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  fl;
  } vec_t;

  initial begin
    int         lat;
    logic [2:0] fl;
    vec_t       t2 [4];
    int         acc_cyc [2];
    logic [2:0] rsp_fl [2];
    int         nacc, nrsp;
    logic       seen;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_ready_rsp = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_flags", {rsp_exec, rsp_cached, rsp_nonidem}, 0);

    // T1
    lookup(64'h8000_1000, lat, fl);
    check("t1_latency", lat, 4);
    check("t1_flags", fl, 3'b110);

    // T2: region bounds
    t2[0] = '{64'hFFF,    3'b100};
    t2[1] = '{64'h1000,   3'b000};
    t2[2] = '{64'h1_FFFF, 3'b100};
    t2[3] = '{64'h2_0000, 3'b000};
    foreach (t2[i]) begin
      lookup(t2[i].addr, lat, fl);
      check($sformatf("t2_flags_%0h", t2[i].addr), fl, t2[i].fl);
    end

    // T3: response backpressure
    tick();
    rsp_ready = 1'b0;
    lookup(64'h8000_1000, lat, fl);
    check("t3_latency", lat, 4);
    req_valid = 1'b1;
    req_addr  = 64'h0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t3_hold_%0d", c),
            {rsp_valid, req_ready, rsp_exec, rsp_cached, rsp_nonidem}, 5'b10110);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("t3_release_idle", {rsp_valid, req_ready, busy}, 3'b010);
    tick();
    check("t3_not_queued", {rsp_valid, req_ready, busy}, 3'b010);

    // T4: reset in SCAN cycle 2 drops the lookup
    req_valid = 1'b1;
    req_addr  = 64'h8000_1000;
    tick();
    req_valid = 1'b0;
    tick();
    check("t4_in_scan", {busy, rsp_valid}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_after_reset", {req_ready, rsp_valid, busy}, 3'b100);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen |= rsp_valid;
    end
    check("t4_no_response", seen, 0);

    // T5: top-of-memory rule and the M=0 instance
    a_valid = 1'b1;
    a_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    a_valid = 1'b0;
    check("t5_zero_rsp_cycle1", {z_rsp_valid, z_exec, z_cached, z_nonidem}, 4'b1000);
    check("t5_wrap_scan", w_rsp_valid, 0);
    tick();
    check("t5_wrap_top_hit", {w_rsp_valid, w_exec, w_cached, w_nonidem}, 4'b1100);
    tick();
    a_valid = 1'b1;
    a_addr  = 64'h0;
    tick();
    a_valid = 1'b0;
    tick();
    check("t5_wrap_zero_miss", {w_rsp_valid, w_exec}, 2'b10);
    tick();

    // T6: back-to-back with req_valid held high
    nacc = 0; nrsp = 0;
    req_valid = 1'b1;
    req_addr  = 64'h8000_0000;
    for (int t = 0; t < 16; t++) begin
      if (rsp_valid && nrsp < 2) begin
        rsp_fl[nrsp] = {rsp_exec, rsp_cached, rsp_nonidem};
        nrsp++;
      end
      if (req_ready && req_valid && nacc < 2) begin
        acc_cyc[nacc] = t;
        nacc++;
      end else if (!req_ready && nacc == 1) begin
        req_addr = 64'h1_0004;
      end else if (!req_ready && nacc == 2) begin
        req_valid = 1'b0;
      end
      tick();
    end
    req_valid = 1'b0;
    check("t6_accepts", nacc, 2);
    check("t6_responses", nrsp, 2);
    if (nacc == 2) check("t6_accept_gap", acc_cyc[1] - acc_cyc[0], 5);
    if (nrsp == 2) begin
      check("t6_flags_first", rsp_fl[0], 3'b110);
      check("t6_flags_second", rsp_fl[1], 3'b100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
